// File: rtl/dstack_ctrl.sv
// dstack_ctrl: op sequencer for the core0 data stack, with occupancy checks and a sticky fault.
// Optional macro DSTACK_CTRL_HIGHWATER_EN adds the high_water output. Rev 1.0
`default_nettype none

module dstack_ctrl #(
    parameter int DEPTH_MAG = 7,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [3:0]           op_code,
    input  logic [WIDTH-1:0]     op_imm,
    input  logic [5:0]           op_n,
    output logic [1:0]           stk_movement,
    output logic [WIDTH-1:0]     stk_new_top,
    output logic                 stk_rotate,
    output logic [5:0]           stk_rot_addr,
    input  logic [WIDTH-1:0]     stk_top,
    input  logic [WIDTH-1:0]     stk_second,
    input  logic [WIDTH-1:0]     stk_rot_val,
    input  logic                 stk_overflow,
    output logic [DEPTH_MAG:0]   depth,
    output logic                 fault,
    output logic [1:0]           fault_code,
    input  logic                 fault_ack
`ifdef DSTACK_CTRL_HIGHWATER_EN
    ,
    output logic [DEPTH_MAG:0]   high_water
`endif
);

    localparam int CW = (DEPTH_MAG + 2 > 7) ? DEPTH_MAG + 2 : 7;

    localparam logic [3:0] c_OP_NOP   = 4'd0;
    localparam logic [3:0] c_OP_PUSH  = 4'd1;
    localparam logic [3:0] c_OP_POP   = 4'd2;
    localparam logic [3:0] c_OP_DROP2 = 4'd3;
    localparam logic [3:0] c_OP_DUP   = 4'd4;
    localparam logic [3:0] c_OP_COPY  = 4'd5;
    localparam logic [3:0] c_OP_ROT   = 4'd6;
    localparam logic [3:0] c_OP_ADD   = 4'd7;
    localparam logic [3:0] c_OP_SUB   = 4'd8;
    localparam logic [3:0] c_OP_DROPN = 4'd9;

    localparam logic [1:0] c_MV_NONE = 2'b00;
    localparam logic [1:0] c_MV_PUSH = 2'b01;
    localparam logic [1:0] c_MV_POP  = 2'b10;
    localparam logic [1:0] c_MV_POP2 = 2'b11;

    localparam logic [DEPTH_MAG:0] c_FULL = {1'b1, {DEPTH_MAG{1'b0}}};
    localparam logic [DEPTH_MAG:0] c_ONE  = {{DEPTH_MAG{1'b0}}, 1'b1};
    localparam logic [DEPTH_MAG:0] c_TWO  = {{(DEPTH_MAG-1){1'b0}}, 2'b10};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DROP = 1'b1
    } state_t;

    state_t                 r_state;
    logic [5:0]             r_rem;
    logic [DEPTH_MAG:0]     r_depth;
    logic                   r_fault;
    logic [1:0]             r_fault_code;

    logic                   w_accept;
    logic [1:0]             w_viol;
    logic [CW-1:0]          w_n;
    logic [CW-1:0]          w_d;
    logic                   w_full;
    logic [DEPTH_MAG:0]     w_depth_next;

    assign op_ready   = (r_state == S_IDLE) && !r_fault;
    assign w_accept   = op_valid && op_ready;
    assign depth      = r_depth;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

    // Common-width copies so index and occupancy compare without truncation.
    assign w_n    = {{(CW-6){1'b0}}, op_n};
    assign w_d    = {{(CW-DEPTH_MAG-1){1'b0}}, r_depth};
    assign w_full = (r_depth == c_FULL);

    always_comb begin
        w_viol = 2'd0;
        case (op_code)
            c_OP_NOP:   w_viol = 2'd0;
            c_OP_PUSH:  if (w_full) w_viol = 2'd2;
            c_OP_POP:   if (r_depth == '0) w_viol = 2'd1;
            c_OP_DUP: begin
                if (r_depth == '0)  w_viol = 2'd1;
                else if (w_full)    w_viol = 2'd2;
            end
            c_OP_DROP2, c_OP_ADD, c_OP_SUB: if (r_depth < c_TWO) w_viol = 2'd1;
            c_OP_COPY: begin
                if (op_n == 6'd0 || w_d <= w_n) w_viol = 2'd1;
                else if (w_full)                w_viol = 2'd2;
            end
            c_OP_ROT:   if (op_n == 6'd0 || w_d <= w_n) w_viol = 2'd1;
            c_OP_DROPN: if (w_n > w_d) w_viol = 2'd1;
            default:    w_viol = 2'd3;
        endcase
    end

    always_comb begin
        stk_movement = c_MV_NONE;
        stk_new_top  = stk_top;
        stk_rotate   = 1'b0;
        stk_rot_addr = 6'd0;
        w_depth_next = r_depth;
        if (r_state == S_IDLE && w_accept && w_viol == 2'd0) begin
            case (op_code)
                c_OP_PUSH: begin
                    stk_movement = c_MV_PUSH;
                    stk_new_top  = op_imm;
                    w_depth_next = r_depth + c_ONE;
                end
                c_OP_POP: begin
                    stk_movement = c_MV_POP;
                    stk_new_top  = stk_second;
                    w_depth_next = r_depth - c_ONE;
                end
                c_OP_DROP2: begin
                    stk_movement = c_MV_POP2;
                    stk_rot_addr = 6'd1;
                    stk_new_top  = stk_rot_val;
                    w_depth_next = r_depth - c_TWO;
                end
                c_OP_DUP: begin
                    stk_movement = c_MV_PUSH;
                    w_depth_next = r_depth + c_ONE;
                end
                c_OP_COPY: begin
                    stk_movement = c_MV_PUSH;
                    stk_rot_addr = op_n - 6'd1;
                    stk_new_top  = stk_rot_val;
                    w_depth_next = r_depth + c_ONE;
                end
                c_OP_ROT: begin
                    stk_rotate   = 1'b1;
                    stk_rot_addr = op_n - 6'd1;
                    stk_new_top  = stk_rot_val;
                end
                c_OP_ADD: begin
                    stk_movement = c_MV_POP;
                    stk_new_top  = stk_second + stk_top;
                    w_depth_next = r_depth - c_ONE;
                end
                c_OP_SUB: begin
                    stk_movement = c_MV_POP;
                    stk_new_top  = stk_second - stk_top;
                    w_depth_next = r_depth - c_ONE;
                end
                default: ;
            endcase
        end else if (r_state == S_DROP && !r_fault) begin
            if (r_rem >= 6'd2) begin
                stk_movement = c_MV_POP2;
                stk_rot_addr = 6'd1;
                stk_new_top  = stk_rot_val;
                w_depth_next = r_depth - c_TWO;
            end else begin
                stk_movement = c_MV_POP;
                stk_new_top  = stk_second;
                w_depth_next = r_depth - c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rem        <= 6'd0;
            r_depth      <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'd0;
        end else begin
            r_depth <= w_depth_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_viol == 2'd0 && op_code == c_OP_DROPN && op_n != 6'd0) begin
                        r_state <= S_DROP;
                        r_rem   <= op_n;
                    end
                end
                S_DROP: begin
                    // A fault raised mid-sequence freezes the drop until acknowledged.
                    if (!r_fault) begin
                        if (r_rem >= 6'd2) r_rem <= r_rem - 6'd2;
                        else               r_rem <= 6'd0;
                        if (r_rem <= 6'd2) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (r_fault) begin
                if (fault_ack) begin
                    r_fault      <= 1'b0;
                    r_fault_code <= 2'd0;
                end
            end else if (w_accept && w_viol != 2'd0) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_viol;
            end else if (stk_overflow) begin
                r_fault      <= 1'b1;
                r_fault_code <= 2'd3;
            end
        end
    end

`ifdef DSTACK_CTRL_HIGHWATER_EN
    logic [DEPTH_MAG:0] r_high_water;
    assign high_water = r_high_water;

    always_ff @(posedge clk) begin
        if (reset)                           r_high_water <= '0;
        else if (w_depth_next > r_high_water) r_high_water <= w_depth_next;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dstack_ctrl.sv
// tb_dstack_ctrl: directed bench for dstack_ctrl with a behavioural data stack model. Rev 1.0
`default_nettype none

module tb_dstack_ctrl;

    localparam int DEPTH_MAG = 7;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 1 << DEPTH_MAG;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 op_valid = 1'b0;
    logic                 op_ready;
    logic [3:0]           op_code = 4'd0;
    logic [WIDTH-1:0]     op_imm = '0;
    logic [5:0]           op_n = 6'd0;
    logic [1:0]           stk_movement;
    logic [WIDTH-1:0]     stk_new_top;
    logic                 stk_rotate;
    logic [5:0]           stk_rot_addr;
    logic [WIDTH-1:0]     stk_top;
    logic [WIDTH-1:0]     stk_second;
    logic [WIDTH-1:0]     stk_rot_val;
    logic                 stk_overflow = 1'b0;
    logic [DEPTH_MAG:0]   depth;
    logic                 fault;
    logic [1:0]           fault_code;
    logic                 fault_ack = 1'b0;
`ifdef DSTACK_CTRL_HIGHWATER_EN
    logic [DEPTH_MAG:0]   high_water;
`endif

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] m [0:DEPTH+1];

    always #5 clk = ~clk;

    dstack_ctrl #(.DEPTH_MAG(DEPTH_MAG), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_imm       (op_imm),
        .op_n         (op_n),
        .stk_movement (stk_movement),
        .stk_new_top  (stk_new_top),
        .stk_rotate   (stk_rotate),
        .stk_rot_addr (stk_rot_addr),
        .stk_top      (stk_top),
        .stk_second   (stk_second),
        .stk_rot_val  (stk_rot_val),
        .stk_overflow (stk_overflow),
        .depth        (depth),
        .fault        (fault),
        .fault_code   (fault_code),
        .fault_ack    (fault_ack)
`ifdef DSTACK_CTRL_HIGHWATER_EN
        ,
        .high_water   (high_water)
`endif
    );

    // Data stack model: registers the controller's requests, element 0 is the top.
    assign stk_top     = m[0];
    assign stk_second  = m[1];
    assign stk_rot_val = m[int'(stk_rot_addr) + 1];

    always @(posedge clk) begin
        m[0] <= stk_new_top;
        case (stk_movement)
            2'b01: for (int i = DEPTH + 1; i >= 1; i--) m[i] <= m[i-1];
            2'b10: for (int i = 1; i <= DEPTH; i++) m[i] <= m[i+1];
            2'b11: for (int i = 1; i <= DEPTH - 1; i++) m[i] <= m[i+2];
            default: if (stk_rotate)
                for (int i = 1; i <= DEPTH + 1; i++)
                    if (i <= int'(stk_rot_addr) + 1) m[i] <= m[i-1];
        endcase
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [3:0] code, input logic [WIDTH-1:0] imm, input logic [5:0] n);
        @(negedge clk);
        op_code = code; op_imm = imm; op_n = n; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0; op_imm = '0; op_n = 6'd0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (depth !== 8'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b exp=0", fault); end
        total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", op_ready); end
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL reset_mv got=%0b exp=00", stk_movement); end
    endtask

    task automatic test_arith();
        do_reset();
        send(4'd1, 32'd5, 6'd0);
        send(4'd1, 32'd7, 6'd0);
        @(negedge clk);
        op_code = 4'd7; op_valid = 1'b1;
        #1;
        total++; if (stk_new_top !== 32'd12) begin bad++; $display("FAIL add_new_top got=%0d exp=12", stk_new_top); end
        total++; if (stk_movement !== 2'b10) begin bad++; $display("FAIL add_mv got=%0b exp=10", stk_movement); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0;
        #1;
        total++; if (stk_top !== 32'd12) begin bad++; $display("FAIL add_top got=%0d exp=12", stk_top); end
        total++; if (depth !== 8'd1) begin bad++; $display("FAIL add_depth got=%0d exp=1", depth); end
        send(4'd1, 32'd20, 6'd0);
        @(negedge clk);
        op_code = 4'd8; op_valid = 1'b1;
        #1;
        total++; if (stk_new_top !== 32'hFFFF_FFF8) begin bad++; $display("FAIL sub_new_top got=%0h exp=fffffff8", stk_new_top); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0;
        #1;
        total++; if (depth !== 8'd1) begin bad++; $display("FAIL sub_depth got=%0d exp=1", depth); end
    endtask

    task automatic test_rot();
        do_reset();
        send(4'd1, 32'd1, 6'd0);
        send(4'd1, 32'd2, 6'd0);
        send(4'd1, 32'd3, 6'd0);
        @(negedge clk);
        op_code = 4'd6; op_n = 6'd2; op_valid = 1'b1;
        #1;
        total++; if (stk_rotate !== 1'b1) begin bad++; $display("FAIL rot_rotate got=%0b exp=1", stk_rotate); end
        total++; if (stk_rot_addr !== 6'd1) begin bad++; $display("FAIL rot_addr got=%0d exp=1", stk_rot_addr); end
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL rot_mv got=%0b exp=00", stk_movement); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0; op_n = 6'd0;
        #1;
        total++; if (stk_top !== 32'd1) begin bad++; $display("FAIL rot_top got=%0d exp=1", stk_top); end
        total++; if (stk_second !== 32'd3) begin bad++; $display("FAIL rot_second got=%0d exp=3", stk_second); end
        total++; if (depth !== 8'd3) begin bad++; $display("FAIL rot_depth got=%0d exp=3", depth); end
    endtask

    task automatic test_dropn();
        logic [1:0] exp_mv [0:3];
        logic [7:0] exp_d  [0:3];
        logic       exp_rd [0:3];
        exp_mv = '{2'b11, 2'b11, 2'b10, 2'b00};
        exp_d  = '{8'd5, 8'd3, 8'd1, 8'd0};
        exp_rd = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 1; i <= 5; i++) send(4'd1, WIDTH'(i * 10), 6'd0);
        @(negedge clk);
        op_code = 4'd9; op_n = 6'd5; op_valid = 1'b1;
        #1;
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL dropn_accept_mv got=%0b exp=00", stk_movement); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            op_valid = 1'b0; op_code = 4'd0; op_n = 6'd0;
            #1;
            total++; if (stk_movement !== exp_mv[c]) begin bad++; $display("FAIL dropn_mv[%0d] got=%0b exp=%0b", c, stk_movement, exp_mv[c]); end
            total++; if (depth !== exp_d[c]) begin bad++; $display("FAIL dropn_depth[%0d] got=%0d exp=%0d", c, depth, exp_d[c]); end
            total++; if (op_ready !== exp_rd[c]) begin bad++; $display("FAIL dropn_ready[%0d] got=%0b exp=%0b", c, op_ready, exp_rd[c]); end
            if (c == 1) begin
                total++; if (stk_top !== 32'd30) begin bad++; $display("FAIL dropn_top got=%0d exp=30", stk_top); end
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        @(negedge clk);
        op_code = 4'd2; op_valid = 1'b1;
        #1;
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL uf_mv got=%0b exp=00", stk_movement); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0;
        #1;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL uf_fault got=%0b exp=1", fault); end
        total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL uf_code got=%0d exp=1", fault_code); end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL uf_ready got=%0b exp=0", op_ready); end
        stk_overflow = 1'b1;
        @(negedge clk);
        stk_overflow = 1'b0;
        #1;
        total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL uf_first_wins got=%0d exp=1", fault_code); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL uf_ack_fault got=%0b exp=0", fault); end
        total++; if (fault_code !== 2'd0) begin bad++; $display("FAIL uf_ack_code got=%0d exp=0", fault_code); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL uf_ack_ready got=%0b exp=1", op_ready); end
        total++; if (depth !== 8'd0) begin bad++; $display("FAIL uf_ack_depth got=%0d exp=0", depth); end
    endtask

    task automatic test_copy();
        do_reset();
        send(4'd1, 32'd100, 6'd0);
        send(4'd1, 32'd200, 6'd0);
        send(4'd1, 32'd300, 6'd0);
        @(negedge clk);
        op_code = 4'd5; op_n = 6'd2; op_valid = 1'b1;
        #1;
        total++; if (stk_movement !== 2'b01) begin bad++; $display("FAIL copy_mv got=%0b exp=01", stk_movement); end
        total++; if (stk_rot_addr !== 6'd1) begin bad++; $display("FAIL copy_addr got=%0d exp=1", stk_rot_addr); end
        total++; if (stk_new_top !== 32'd100) begin bad++; $display("FAIL copy_new_top got=%0d exp=100", stk_new_top); end
        @(negedge clk);
        op_n = 6'd4;
        #1;
        total++; if (depth !== 8'd4) begin bad++; $display("FAIL copy_depth got=%0d exp=4", depth); end
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL copy_uf_mv got=%0b exp=00", stk_movement); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0; op_n = 6'd0;
        #1;
        total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL copy_uf_code got=%0d exp=1", fault_code); end
        total++; if (depth !== 8'd4) begin bad++; $display("FAIL copy_uf_depth got=%0d exp=4", depth); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        send(4'd9, '0, 6'd5);
        #1;
        total++; if (fault_code !== 2'd1) begin bad++; $display("FAIL dropn_uf_code got=%0d exp=1", fault_code); end
        total++; if (depth !== 8'd4) begin bad++; $display("FAIL dropn_uf_depth got=%0d exp=4", depth); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(4'd1, WIDTH'(i), 6'd0);
        #1;
        total++; if (depth !== 8'd128) begin bad++; $display("FAIL full_depth got=%0d exp=128", depth); end
`ifdef DSTACK_CTRL_HIGHWATER_EN
        total++; if (high_water !== 8'd128) begin bad++; $display("FAIL high_water got=%0d exp=128", high_water); end
`endif
        @(negedge clk);
        op_code = 4'd4; op_valid = 1'b1;
        #1;
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL of_mv got=%0b exp=00", stk_movement); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL of_ready got=%0b exp=1", op_ready); end
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0;
        #1;
        total++; if (fault_code !== 2'd2) begin bad++; $display("FAIL of_code got=%0d exp=2", fault_code); end
        total++; if (depth !== 8'd128) begin bad++; $display("FAIL of_depth got=%0d exp=128", depth); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        send(4'd12, '0, 6'd0);
        #1;
        total++; if (fault_code !== 2'd3) begin bad++; $display("FAIL illegal_code got=%0d exp=3", fault_code); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        stk_overflow = 1'b1;
        @(negedge clk);
        stk_overflow = 1'b0;
        #1;
        total++; if (fault !== 1'b1 || fault_code !== 2'd3) begin bad++; $display("FAIL stkov got=%0b/%0d exp=1/3", fault, fault_code); end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
    endtask

    task automatic test_reset_dropn();
        do_reset();
        for (int i = 1; i <= 4; i++) send(4'd1, WIDTH'(i), 6'd0);
        @(negedge clk);
        op_code = 4'd9; op_n = 6'd4; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; op_code = 4'd0; op_n = 6'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (depth !== 8'd0) begin bad++; $display("FAIL rst_drop_depth got=%0d exp=0", depth); end
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_drop_ready got=%0b exp=1", op_ready); end
        total++; if (stk_movement !== 2'b00) begin bad++; $display("FAIL rst_drop_mv got=%0b exp=00", stk_movement); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_rot();
        test_dropn();
        test_underflow();
        test_copy();
        test_overflow();
        test_reset_dropn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/dstack_ctrl.md
Name: dstack_ctrl

Overview:
- Op sequencer directly upstream of the core0 data stack.
- Accepts decoded stack ops over a valid/ready handshake and converts each one into the data stack's per-cycle controls: movement, new_top, rotate and rot_addr.
- Keeps an occupancy count and checks every op for underflow or overflow before issuing it. A detected violation raises a sticky fault.
- Sequences the multi-cycle DROPN op using double pops.

Parameters:
- DEPTH_MAG, 7, log2 of the data stack depth; DEPTH = 1 << DEPTH_MAG.
- WIDTH, 32, data word width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  op offered
- op_ready  out  1  op accepted when op_valid & op_ready
- op_code  in  4  0 NOP, 1 PUSH, 2 POP, 3 DROP2, 4 DUP, 5 COPY, 6 ROT, 7 ADD, 8 SUB, 9 DROPN; 10-15 illegal
- op_imm  in  WIDTH  PUSH value
- op_n  in  6  element index for COPY/ROT; count for DROPN
- stk_movement  out  2  to stack: 00 none, 01 push, 10 pop, 11 double pop
- stk_new_top  out  WIDTH  to stack: next top
- stk_rotate  out  1  to stack: rotate
- stk_rot_addr  out  6  to stack: rotate/copy address; the stack returns element rot_addr+1 on stk_rot_val
- stk_top  in  WIDTH  stack top
- stk_second  in  WIDTH  stack element 1
- stk_rot_val  in  WIDTH  stack element rot_addr+1
- stk_overflow  in  1  stack overflow indication
- depth  out  DEPTH_MAG+1  valid element count, including top (0..DEPTH)
- fault  out  1  sticky fault
- fault_code  out  2  1 underflow, 2 overflow, 3 illegal op/stack overflow
- fault_ack  in  1  clears fault

Behaviour:
- Reset values: depth=0, state IDLE, fault=0, fault_code=0. Reset during DROPN aborts it.
- States:
  - IDLE: op_ready = !fault.
  - DROP: op_ready = 0.
- Stack outputs are combinational from the accepted op. The stack registers them, so the result appears on stk_top one cycle after acceptance.
- Default stack outputs whenever no op is issued (idle, fault, or op_valid=0): movement 00, new_top = stk_top, rotate 0, rot_addr 0.
- Op mapping (stack outputs, depth change):
  - NOP: defaults; depth unchanged.
  - PUSH: movement 01, new_top = op_imm; depth +1.
  - POP: movement 10, new_top = stk_second; depth -1.
  - DROP2: movement 11, rot_addr = 1, new_top = stk_rot_val; depth -2.
  - DUP: movement 01, new_top = stk_top; depth +1.
  - COPY n (n≥1): movement 01, rot_addr = n-1, new_top = stk_rot_val; depth +1.
  - ROT n (n≥1): rotate = 1, movement 00, rot_addr = n-1, new_top = stk_rot_val; depth unchanged. ROT 1 is a swap.
  - ADD: movement 10, new_top = stk_second + stk_top (mod 2^WIDTH); depth -1.
  - SUB: movement 10, new_top = stk_second - stk_top (mod 2^WIDTH); depth -1.
  - DROPN n: n=0 behaves as NOP. n≥1 enters DROP with rem = n.
- DROP state, once per cycle:
  - rem ≥ 2: issue the DROP2 controls, rem -= 2, depth -= 2.
  - rem = 1: issue the POP controls, rem = 0, depth -= 1.
  - Return to IDLE in the cycle rem reaches 0. DROPN n takes ceil(n/2) cycles.
- Pre-checks, evaluated at acceptance against the current depth. A failing op is consumed (handshake completes), nothing is issued to the stack, depth is unchanged, and the fault is raised:
  - Underflow (code 1):
    - POP or DUP with depth < 1.
    - DROP2, ADD or SUB with depth < 2.
    - COPY/ROT with n = 0 or depth ≤ n.
    - DROPN with n > depth.
  - Overflow (code 2): PUSH, DUP or COPY with depth = DEPTH.
  - Illegal op (code 3): op_code 10-15.
- stk_overflow asserted in any cycle sets fault with code 3.
- Fault handling:
  - fault and fault_code register on the cycle after the violation.
  - While fault=1: op_ready = 0 and default stack outputs.
  - fault_ack clears fault and fault_code on the next cycle; depth is retained.
  - The first fault wins: fault_code is not overwritten while fault=1.
- Boundaries: depth never wraps; the full (DEPTH) and empty (0) limits are enforced solely by the pre-checks.

Optional Feature:
- Macro DSTACK_CTRL_HIGHWATER_EN.
- Defined: adds output high_water (DEPTH_MAG+1 bits).
  - Reset 0.
  - Updates to max(high_water, next depth) each cycle.
  - fault_ack does not clear it; only reset clears it.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset, then PUSH 5, PUSH 7, ADD → stk_new_top = 12 in the ADD cycle; stk_top = 12 and depth = 1 the next cycle.
- PUSH 1, 2, 3, then ROT 2 → stk_rotate = 1, stk_rot_addr = 1; stk_top = 1 after; depth stays 3.
- PUSH 10, 20, 30, 40, 50, then DROPN 5 → op_ready low for 3 cycles; movement sequence 11, 11, 10; depth = 0 at the end.
- From empty, POP → no movement issued; fault = 1, code 1; op_ready = 0 until fault_ack; then op_ready = 1 with depth = 0.
- DEPTH PUSHes, then DUP → DUP consumed but not issued; fault code 2; depth = DEPTH. op_code 12 after ack → fault code 3.
- Reset asserted in the second cycle of DROPN 4 → next cycle: depth = 0, IDLE, op_ready = 1, movement 00.
